// File: rtl/fpu_share_sched.sv
// Shares one in-order pipelined FPU unit between NumIn requesters.
// Round-robin issue with lock-in under backpressure, a tag FIFO that
// remembers who issued each in-flight operation, and in-order routing of
// results back to the requester at the head of that FIFO.
module fpu_share_sched #(
   parameter int NumIn          = 4,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 4,
   parameter int IdxWidth       = $clog2(NumIn)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               flush_i,
   input  logic [NumIn-1:0]                   in_valid_i,
   output logic [NumIn-1:0]                   in_ready_o,
   input  logic [NumIn-1:0][DataWidth-1:0]    in_data_i,
   output logic                               unit_valid_o,
   input  logic                               unit_ready_i,
   output logic [DataWidth-1:0]               unit_data_o,
   output logic [IdxWidth-1:0]                unit_idx_o,
   input  logic                               rsp_valid_i,
   output logic                               rsp_ready_o,
   input  logic [DataWidth-1:0]               rsp_data_i,
   output logic [NumIn-1:0]                   out_valid_o,
   input  logic [NumIn-1:0]                   out_ready_i,
   output logic [DataWidth-1:0]               out_data_o,
   output logic [$clog2(MaxOutstanding):0]    outstanding_o,
   output logic                               err_o
);

   localparam int PtrWidth = $clog2(MaxOutstanding);
   localparam int CntWidth = PtrWidth + 1;
   localparam logic [CntWidth-1:0] FullCount = CntWidth'(MaxOutstanding);

   typedef enum logic {
      LockFree,
      LockHeld
   } LockState;

   LockState            lockStateQ, lockStateD;
   logic [IdxWidth-1:0] lockIdxQ, lockIdxD;
   logic [IdxWidth-1:0] rrQ, rrD;
   logic [IdxWidth-1:0] winnerIdx;
   logic [IdxWidth-1:0] headIdx;
   logic [IdxWidth-1:0] tagMem [MaxOutstanding];
   logic [PtrWidth-1:0] wrPtrQ, rdPtrQ;
   logic [CntWidth-1:0] cntQ, cntD;
   logic                errQ;
   logic                anyValid;
   logic                fifoFull;
   logic                fifoEmpty;
   logic                issueFire;
   logic                rspPop;

   // Picks the requester to present to the unit. While a stalled offer is
   // locked, the previously offered index is kept so the unit sees a stable
   // operation; otherwise scan upward from the priority pointer, wrapping.
   always_comb begin
      int  cand;
      logic found;
      winnerIdx = rrQ;
      found     = 1'b0;
      cand      = 0;
      if (lockStateQ == LockHeld) begin
         winnerIdx = lockIdxQ;
      end else begin
         for (int off = 0; off < NumIn; off++) begin
            cand = int'(rrQ) + off;
            if (cand >= NumIn) begin
               cand = cand - NumIn;
            end
            if (!found && in_valid_i[IdxWidth'(cand)]) begin
               winnerIdx = IdxWidth'(cand);
               found     = 1'b1;
            end
         end
      end
   end

   // Issue side handshake. Issue is blocked purely on the registered
   // occupancy, so a response draining a full FIFO does not let an issue
   // slip through in the same cycle.
   always_comb begin
      anyValid     = |in_valid_i;
      fifoFull     = (cntQ == FullCount);
      fifoEmpty    = (cntQ == '0);
      unit_valid_o = anyValid & ~fifoFull;
      issueFire    = unit_valid_o & unit_ready_i;
      unit_idx_o   = unit_valid_o ? winnerIdx : '0;
      unit_data_o  = unit_valid_o ? in_data_i[winnerIdx] : '0;
      in_ready_o   = '0;
      if (issueFire) begin
         in_ready_o[winnerIdx] = 1'b1;
      end
   end

   // After an accepted issue, priority moves to the next valid requester
   // above the winner so nobody can be starved; with no other contender the
   // pointer stays put. A flush returns priority to requester 0.
   always_comb begin
      int  cand;
      logic found;
      rrD   = rrQ;
      found = 1'b0;
      cand  = 0;
      if (issueFire) begin
         for (int off = 1; off < NumIn; off++) begin
            cand = int'(winnerIdx) + off;
            if (cand >= NumIn) begin
               cand = cand - NumIn;
            end
            if (!found && in_valid_i[IdxWidth'(cand)]) begin
               rrD   = IdxWidth'(cand);
               found = 1'b1;
            end
         end
      end
      if (flush_i) begin
         rrD = '0;
      end
   end

   // Lock-in state machine: an offer the unit did not take is held for the
   // next cycle; an accepted offer or a flush releases it.
   always_comb begin
      lockStateD = LockFree;
      lockIdxD   = lockIdxQ;
      if (unit_valid_o && !unit_ready_i) begin
         lockStateD = LockHeld;
         lockIdxD   = winnerIdx;
      end
      if (flush_i) begin
         lockStateD = LockFree;
      end
   end

   // Result routing: the oldest tag says which requester owns the result.
   // With nothing in flight, a response is swallowed (ready high) and
   // flagged as spurious instead of being routed anywhere.
   always_comb begin
      headIdx     = tagMem[rdPtrQ];
      out_valid_o = '0;
      if (!fifoEmpty) begin
         out_valid_o[headIdx] = rsp_valid_i;
      end
      rsp_ready_o = fifoEmpty ? rsp_valid_i : out_ready_i[headIdx];
      out_data_o  = fifoEmpty ? '0 : rsp_data_i;
      rspPop      = ~fifoEmpty & rsp_valid_i & rsp_ready_o;
   end

   // Occupancy bookkeeping; a push and a pop in the same cycle cancel out.
   always_comb begin
      unique case ({issueFire, rspPop})
         2'b10:   cntD = cntQ + CntWidth'(1);
         2'b01:   cntD = cntQ - CntWidth'(1);
         default: cntD = cntQ;
      endcase
   end

   // State registers. Reset wins over flush and over every handshake and
   // throws away any in-flight tags; the tag storage itself needs no reset
   // because the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lockStateQ <= LockFree;
         lockIdxQ   <= '0;
         rrQ        <= '0;
         wrPtrQ     <= '0;
         rdPtrQ     <= '0;
         cntQ       <= '0;
         errQ       <= 1'b0;
      end else begin
         lockStateQ <= lockStateD;
         lockIdxQ   <= lockIdxD;
         rrQ        <= rrD;
         cntQ       <= cntD;
         if (issueFire) begin
            tagMem[wrPtrQ] <= winnerIdx;
            wrPtrQ         <= wrPtrQ + PtrWidth'(1);
         end
         if (rspPop) begin
            rdPtrQ <= rdPtrQ + PtrWidth'(1);
         end
         if (fifoEmpty && rsp_valid_i) begin
            errQ <= 1'b1;
         end
      end
   end

   assign outstanding_o = cntQ;
   assign err_o         = errQ;

endmodule

// File: tb/tb_fpu_share_sched.sv
// Directed bench for fpu_share_sched with NumIn=4, MaxOutstanding=4.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fpu_share_sched;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [3:0]       inValid;
   logic [3:0]       inReady;
   logic [3:0][31:0] inData;
   logic             unitValid;
   logic             unitReady;
   logic [31:0]      unitData;
   logic [1:0]       unitIdx;
   logic             rspValid;
   logic             rspReady;
   logic [31:0]      rspData;
   logic [3:0]       outValid;
   logic [3:0]       outReady;
   logic [31:0]      outData;
   logic [2:0]       outstanding;
   logic             err;

   int vecCount = 0;
   int errCount = 0;

   fpu_share_sched #(
      .NumIn(4),
      .DataWidth(32),
      .MaxOutstanding(4)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .flush_i(flush),
      .in_valid_i(inValid),
      .in_ready_o(inReady),
      .in_data_i(inData),
      .unit_valid_o(unitValid),
      .unit_ready_i(unitReady),
      .unit_data_o(unitData),
      .unit_idx_o(unitIdx),
      .rsp_valid_i(rspValid),
      .rsp_ready_o(rspReady),
      .rsp_data_i(rspData),
      .out_valid_o(outValid),
      .out_ready_i(outReady),
      .out_data_o(outData),
      .outstanding_o(outstanding),
      .err_o(err)
   );

   // Free-running 10ns clock.
   always #5 clk = ~clk;

   // One idle cycle with flush asserted puts priority back on requester 0.
   task automatic doFlush();
      inValid = 4'b0000;
      unitReady = 1'b0;
      rspValid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vecCount++;
      if ({unitValid, inReady, unitIdx, unitData} !== '0) begin
         errCount++;
         $display("[TB] FAIL reset_issue: got valid=%b rdy=%b idx=%0d data=%h want all 0", unitValid, inReady, unitIdx, unitData);
      end
      vecCount++;
      if ({rspReady, outValid, outData} !== '0) begin
         errCount++;
         $display("[TB] FAIL reset_rsp: got rspRdy=%b outValid=%b outData=%h want all 0", rspReady, outValid, outData);
      end
      vecCount++;
      if ({outstanding, err} !== '0) begin
         errCount++;
         $display("[TB] FAIL reset_state: got outstanding=%0d err=%b want 0/0", outstanding, err);
      end
      @(negedge clk);
   endtask

   task automatic test_rotation();
      logic [1:0] exp;
      doFlush();
      inValid = 4'b1111;
      unitReady = 1'b1;
      for (int k = 0; k < 8; k++) begin
         rspValid = (k > 0);
         exp = 2'(k % 4);
         #1;
         vecCount++;
         if (unitIdx !== exp || inReady !== (4'b0001 << exp) || unitData !== (32'hD000 + 32'(exp))) begin
            errCount++;
            $display("[TB] FAIL rotation_%0d: got idx=%0d rdy=%b data=%h want idx=%0d", k, unitIdx, inReady, unitData, exp);
         end
         if (k > 0) begin
            vecCount++;
            if (outValid !== (4'b0001 << ((k - 1) % 4))) begin
               errCount++;
               $display("[TB] FAIL rotation_route_%0d: got outValid=%b want %b", k, outValid, 4'b0001 << ((k - 1) % 4));
            end
         end
         @(negedge clk);
      end
      inValid = 4'b0000;
      unitReady = 1'b0;
      rspValid = 1'b1;
      #1;
      vecCount++;
      if (outValid !== 4'b1000) begin
         errCount++;
         $display("[TB] FAIL rotation_drain: got outValid=%b want 1000", outValid);
      end
      @(negedge clk);
      rspValid = 1'b0;
      #1;
      vecCount++;
      if (outstanding !== 3'd0 || err !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL rotation_empty: got outstanding=%0d err=%b want 0/0", outstanding, err);
      end
      @(negedge clk);
   endtask

   task automatic test_fairness();
      int fseq[4] = '{1, 3, 1, 3};
      doFlush();
      inValid = 4'b1010;
      unitReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rspValid = (k > 0);
         #1;
         vecCount++;
         if (unitIdx !== 2'(fseq[k]) || inReady !== (4'b0001 << fseq[k])) begin
            errCount++;
            $display("[TB] FAIL fairness_%0d: got idx=%0d rdy=%b want idx=%0d", k, unitIdx, inReady, fseq[k]);
         end
         @(negedge clk);
      end
      inValid = 4'b0000;
      unitReady = 1'b0;
      rspValid = 1'b1;
      @(negedge clk);
      rspValid = 1'b0;
      #1;
      vecCount++;
      if (outstanding !== 3'd0) begin
         errCount++;
         $display("[TB] FAIL fairness_empty: got outstanding=%0d want 0", outstanding);
      end
      @(negedge clk);
   endtask

   task automatic test_lock();
      int tags[4] = '{1, 2, 0, 0};
      doFlush();
      inValid = 4'b0110;
      unitReady = 1'b1;
      #1;
      vecCount++;
      if (unitIdx !== 2'd1) begin
         errCount++;
         $display("[TB] FAIL lock_setup: got idx=%0d want 1", unitIdx);
      end
      @(negedge clk);
      inValid = 4'b0101;
      unitReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         vecCount++;
         if (unitIdx !== 2'd2 || inReady !== 4'b0000 || unitValid !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL lock_stall_%0d: got idx=%0d rdy=%b valid=%b want 2/0000/1", k, unitIdx, inReady, unitValid);
         end
         @(negedge clk);
      end
      unitReady = 1'b1;
      #1;
      vecCount++;
      if (unitIdx !== 2'd2 || inReady !== 4'b0100) begin
         errCount++;
         $display("[TB] FAIL lock_accept: got idx=%0d rdy=%b want 2/0100", unitIdx, inReady);
      end
      @(negedge clk);
      inValid = 4'b0011;
      @(negedge clk);
      inValid = 4'b0001;
      unitReady = 1'b0;
      @(negedge clk);
      inValid = 4'b0011;
      #1;
      vecCount++;
      if (unitIdx !== 2'd0) begin
         errCount++;
         $display("[TB] FAIL lock_hold: got idx=%0d want 0", unitIdx);
      end
      @(negedge clk);
      unitReady = 1'b1;
      #1;
      vecCount++;
      if (unitIdx !== 2'd0 || inReady !== 4'b0001) begin
         errCount++;
         $display("[TB] FAIL lock_release: got idx=%0d rdy=%b want 0/0001", unitIdx, inReady);
      end
      @(negedge clk);
      inValid = 4'b0000;
      unitReady = 1'b0;
      rspValid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         vecCount++;
         if (outValid !== (4'b0001 << tags[k]) || rspReady !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL lock_route_%0d: got outValid=%b rspRdy=%b want %b/1", k, outValid, rspReady, 4'b0001 << tags[k]);
         end
         @(negedge clk);
      end
      rspValid = 1'b0;
      #1;
      vecCount++;
      if (outstanding !== 3'd0) begin
         errCount++;
         $display("[TB] FAIL lock_empty: got outstanding=%0d want 0", outstanding);
      end
      @(negedge clk);
   endtask

   task automatic test_full();
      doFlush();
      inValid = 4'b1111;
      unitReady = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      vecCount++;
      if (outstanding !== 3'd4 || unitValid !== 1'b0 || inReady !== 4'b0000) begin
         errCount++;
         $display("[TB] FAIL full_block: got outstanding=%0d valid=%b rdy=%b want 4/0/0000", outstanding, unitValid, inReady);
      end
      @(negedge clk);
      rspValid = 1'b1;
      #1;
      vecCount++;
      if (unitValid !== 1'b0 || inReady !== 4'b0000 || rspReady !== 1'b1 || outValid !== 4'b0001) begin
         errCount++;
         $display("[TB] FAIL full_pop_no_bypass: got valid=%b rdy=%b rspRdy=%b outValid=%b want 0/0000/1/0001", unitValid, inReady, rspReady, outValid);
      end
      @(negedge clk);
      rspValid = 1'b0;
      #1;
      vecCount++;
      if (outstanding !== 3'd3 || unitValid !== 1'b1 || unitIdx !== 2'd0) begin
         errCount++;
         $display("[TB] FAIL full_resume: got outstanding=%0d valid=%b idx=%0d want 3/1/0", outstanding, unitValid, unitIdx);
      end
      @(negedge clk);
      #1;
      vecCount++;
      if (outstanding !== 3'd4 || unitValid !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL full_refill: got outstanding=%0d valid=%b want 4/0", outstanding, unitValid);
      end
      inValid = 4'b0000;
      unitReady = 1'b0;
      rspValid = 1'b1;
      repeat (4) @(negedge clk);
      rspValid = 1'b0;
      #1;
      vecCount++;
      if (outstanding !== 3'd0) begin
         errCount++;
         $display("[TB] FAIL full_drain: got outstanding=%0d want 0", outstanding);
      end
      @(negedge clk);
   endtask

   task automatic test_routing();
      doFlush();
      inValid = 4'b0100;
      unitReady = 1'b1;
      @(negedge clk);
      inValid = 4'b0001;
      @(negedge clk);
      inValid = 4'b0000;
      unitReady = 1'b0;
      rspValid = 1'b1;
      rspData = 32'h0000BEEF;
      outReady = 4'b1011;
      #1;
      vecCount++;
      if (outValid !== 4'b0100 || rspReady !== 1'b0 || outData !== 32'h0000BEEF) begin
         errCount++;
         $display("[TB] FAIL route_backpressure: got outValid=%b rspRdy=%b data=%h want 0100/0/0000beef", outValid, rspReady, outData);
      end
      @(negedge clk);
      #1;
      vecCount++;
      if (outstanding !== 3'd2 || outValid !== 4'b0100) begin
         errCount++;
         $display("[TB] FAIL route_head_held: got outstanding=%0d outValid=%b want 2/0100", outstanding, outValid);
      end
      @(negedge clk);
      outReady = 4'b1111;
      #1;
      vecCount++;
      if (outValid !== 4'b0100 || rspReady !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL route_first: got outValid=%b rspRdy=%b want 0100/1", outValid, rspReady);
      end
      @(negedge clk);
      rspData = 32'h0000CAFE;
      #1;
      vecCount++;
      if (outValid !== 4'b0001 || outData !== 32'h0000CAFE) begin
         errCount++;
         $display("[TB] FAIL route_second: got outValid=%b data=%h want 0001/0000cafe", outValid, outData);
      end
      @(negedge clk);
      rspValid = 1'b0;
      rspData = 32'h0;
      #1;
      vecCount++;
      if (outstanding !== 3'd0 || err !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL route_empty: got outstanding=%0d err=%b want 0/0", outstanding, err);
      end
      @(negedge clk);
   endtask

   task automatic test_spurious_reset();
      rspValid = 1'b1;
      rspData = 32'h00001234;
      #1;
      vecCount++;
      if (rspReady !== 1'b1 || outValid !== 4'b0000 || err !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL spurious_drop: got rspRdy=%b outValid=%b err=%b want 1/0000/0", rspReady, outValid, err);
      end
      @(negedge clk);
      rspValid = 1'b0;
      rspData = 32'h0;
      #1;
      vecCount++;
      if (err !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL spurious_err: got err=%b want 1", err);
      end
      @(negedge clk);
      #1;
      vecCount++;
      if (err !== 1'b1 || outstanding !== 3'd0) begin
         errCount++;
         $display("[TB] FAIL spurious_sticky: got err=%b outstanding=%0d want 1/0", err, outstanding);
      end
      @(negedge clk);
      inValid = 4'b1111;
      unitReady = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      flush = 1'b1;
      #1;
      vecCount++;
      if (outstanding !== 3'd3) begin
         errCount++;
         $display("[TB] FAIL reset_burst_setup: got outstanding=%0d want 3", outstanding);
      end
      @(negedge clk);
      rst = 1'b0;
      flush = 1'b0;
      inValid = 4'b1001;
      unitReady = 1'b0;
      #1;
      vecCount++;
      if (outstanding !== 3'd0 || err !== 1'b0 || unitIdx !== 2'd0 || unitValid !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL reset_mid_burst: got outstanding=%0d err=%b idx=%0d valid=%b want 0/0/0/1", outstanding, err, unitIdx, unitValid);
      end
      @(negedge clk);
      inValid = 4'b1111;
      unitReady = 1'b1;
      repeat (2) @(negedge clk);
      doFlush();
      inValid = 4'b1001;
      unitReady = 1'b0;
      #1;
      vecCount++;
      if (unitIdx !== 2'd0 || outstanding !== 3'd2 || err !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL flush_keeps_fifo: got idx=%0d outstanding=%0d err=%b want 0/2/0", unitIdx, outstanding, err);
      end
      @(negedge clk);
      inValid = 4'b0000;
   endtask

   // Runs every scenario in order, then prints the summary.
   initial begin
      rst = 1'b1;
      flush = 1'b0;
      inValid = 4'b0000;
      unitReady = 1'b0;
      rspValid = 1'b0;
      rspData = 32'h0;
      outReady = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         inData[i] = 32'hD000 + 32'(i);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_rotation();
      test_fairness();
      test_lock();
      test_full();
      test_routing();
      test_spurious_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule

// File: doc/fpu_share_sched.md
FPU_SHARE_SCHED -- requirements
Module: fpu_share_sched

Interface
REQ-001 SHALL have parameter NumIn, default 4: number of requesters sharing one in-order pipelined FPU unit; legal range 2..16.
REQ-002 SHALL have parameter DataWidth, default 32: operation and result payload width in bits.
REQ-003 SHALL have parameter MaxOutstanding, default 4: maximum number of issued operations without a response; power of two, 2..16.
REQ-004 SHALL have parameter IdxWidth, default $clog2(NumIn): dependent parameter, never overridden.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-007 SHALL have port flush_i, input, 1: clears arbitration state only.
REQ-008 SHALL have port in_valid_i, input, NumIn: per-requester operation valid.
REQ-009 SHALL have port in_ready_o, output, NumIn: per-requester accept.
REQ-010 SHALL have port in_data_i, input, NumIn x DataWidth: per-requester operation payload.
REQ-011 SHALL have port unit_valid_o / unit_ready_i, output / input, 1 each: issue handshake to the unit.
REQ-012 SHALL have port unit_data_o, output, DataWidth: issued payload.
REQ-013 SHALL have port unit_idx_o, output, IdxWidth: index of the requester being issued.
REQ-014 SHALL have port rsp_valid_i / rsp_ready_o, input / output, 1 each: in-order result handshake from the unit.
REQ-015 SHALL have port rsp_data_i, input, DataWidth: result payload.
REQ-016 SHALL have port out_valid_o / out_ready_i, output / input, NumIn each: per-requester result handshake.
REQ-017 SHALL have port out_data_o, output, DataWidth: result payload, shared by all requesters.
REQ-018 SHALL have port outstanding_o, output, $clog2(MaxOutstanding)+1: number of in-flight operations.
REQ-019 SHALL have port err_o, output, 1: sticky flag for a spurious response.

Function
REQ-020 Issue SHALL be combinational (zero latency): unit_valid_o = |in_valid_i & (outstanding_o < MaxOutstanding).
REQ-021 Fair round-robin SHALL be used:
- Priority pointer rr_q holds the highest-priority index.
- The winner is the first valid index at or above rr_q, wrapping to 0.
- On each issue handshake, rr_q SHALL advance to the next valid requester above the winner, wrapping; if no other requester is valid, rr_q SHALL hold.
REQ-022 Lock-in: while unit_valid_o=1 and unit_ready_i=0, the winner index, unit_idx_o and unit_data_o source SHALL be held the next cycle. Requesters SHALL NOT drop an unserved valid.
REQ-023 in_ready_o[w] SHALL equal unit_ready_i & unit_valid_o for winner w only; all other bits SHALL be 0.
REQ-024 Tracking FIFO:
- Each issue handshake SHALL push the winner index into a MaxOutstanding-deep tag FIFO.
- outstanding_o SHALL equal the FIFO occupancy.
REQ-025 Full condition: when occupancy equals MaxOutstanding, unit_valid_o SHALL be 0 and all in_ready_o bits SHALL be 0. A response popped in the same cycle SHALL NOT bypass this; issue resumes the following cycle.
REQ-026 Response routing when the FIFO is non-empty, with head index h:
- out_valid_o[h] = rsp_valid_i; all other out_valid_o bits = 0.
- rsp_ready_o = out_ready_i[h].
- out_data_o = rsp_data_i.
- The head SHALL pop on rsp_valid_i & rsp_ready_o.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged. FIFO pointers SHALL wrap modulo MaxOutstanding.
REQ-028 Spurious response (FIFO empty, rsp_valid_i=1):
- rsp_ready_o SHALL be 1 and the response SHALL be dropped.
- All out_valid_o bits SHALL be 0.
- err_o SHALL be set and held until reset.
REQ-029 flush_i=1 SHALL, at the next edge, set rr_q=0 and release the lock. The FIFO, outstanding_o and err_o SHALL be unaffected. Issue is unaffected in the flush cycle itself.

Reset
REQ-030 rst_i=1 at a rising edge SHALL clear rr_q, lock state, FIFO pointers, outstanding_o and err_o to 0, including mid-operation. In-flight tags are discarded.
REQ-031 After reset, with in_valid_i=0 and rsp_valid_i=0, every output SHALL be 0.
REQ-032 rst_i SHALL take precedence over flush_i and over all handshakes in the same cycle.

Verification
REQ-033 Rotation: NumIn=4, all valid, unit_ready_i=1 for 8 cycles -> unit_idx_o sequence 0,1,2,3,0,1,2,3.
REQ-034 Fairness: valid only on 1 and 3, unit_ready_i=1 -> sequence 1,3,1,3; index 0 and index 2 are never granted.
REQ-035 Lock-in: winner 2 with unit_ready_i=0 for 3 cycles while requester 0 is also valid -> unit_idx_o=2 for all 3 cycles; in_ready_o=4'b0100 on the accepting cycle.
REQ-036 Full: 4 issues with no response -> outstanding_o=4 and unit_valid_o=0. One response plus a same-cycle issue attempt -> no issue that cycle; issue occurs next cycle; outstanding_o=3 then 4.
REQ-037 Routing and backpressure: issue order 2,0 -> first result on out_valid_o[2]. With out_ready_i[2]=0, rsp_ready_o=0 and the FIFO head stays 2.
REQ-038 Spurious response and reset: rsp_valid_i with empty FIFO -> err_o=1 next cycle and persists. rst_i mid-burst with outstanding_o=3 -> outstanding_o=0, err_o=0, rr_q=0 next cycle.
